pwm_fade_ctrl: RTL and testbench
================================

Name: pwm_fade_ctrl

Overview:
- Sequencer that drives the duty input of the 8-bit byte-peripheral PWM, so software does not have to write duty values one at a time.
- Ramps duty from a start value to a target in programmable steps, once per N PWM periods.
- Supports one-shot ramps and continuous triangle "breathing".
- Configured over the same 4-bit address / byte data bus as the other TinyQV byte peripherals.

Parameters:
- TICK_W, 8, width of the interval counter (periods between steps).

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, synchronous, active-low
- address  input  4  register address
- data_write  input  1  write strobe, one cycle per write
- data_in  input  8  write data
- data_out  output  8  read data (combinational on address)
- period_tick  input  1  one-cycle pulse when the PWM counter wraps 255->0
- duty_out  output  8  duty value to the PWM
- busy  output  1  high while a ramp or triangle is running
- done_irq  output  1  sticky done flag, level output

Behaviour:
- Registers:
  - 0 CTRL (W): bit0 START, bit1 TRI (triangle mode), bit2 STOP. Bits are self-clearing; reads return {6'b0, TRI_latched, busy}.
  - 1 TARGET: R/W.
  - 2 STEP: R/W; 0 is treated as 1.
  - 3 INTERVAL: R/W, low TICK_W bits used.
  - 4 STATUS: R returns {6'b0, done, busy}; W1C on bit1.
  - 5 CURRENT: R returns current duty; W loads current only when IDLE, ignored otherwise.
  - Other addresses read 0; writes to them are ignored.
- Reset (rst_n low at clk edge): all registers 0, state IDLE, duty_out=0, busy=0, done_irq=0. A reset mid-ramp aborts immediately; duty_out is 0 on the next cycle.
- States:
  - IDLE: busy=0.
  - On START:
    - latch start=current, tgt=TARGET, TRI, tickcnt=0.
    - If current==TARGET and TRI=0: set done, stay IDLE.
    - Otherwise go to WAIT.
  - WAIT:
    - On each period_tick: if tickcnt==INTERVAL, go to STEP and set tickcnt=0; else tickcnt++.
    - INTERVAL=0 steps on every tick.
  - STEP (one cycle):
    - If current<tgt: current = min(current+STEP, tgt), computed 9-bit, no wrap.
    - If current>tgt: current = max(current-STEP, tgt), no underflow.
    - If the new current==tgt:
      - TRI=0: go to IDLE and set done.
      - TRI=1: swap tgt<->start, return to WAIT.
    - Otherwise return to WAIT.
- STOP in any non-IDLE state: go to IDLE next cycle, current is held, done is not set.
- START while busy is ignored. START and STOP in the same write: STOP wins.
- A period_tick in the same cycle as STEP is lost. This is acceptable because STEP lasts one cycle and ticks are ≥256 cycles apart.
- A TARGET, STEP or INTERVAL write during a ramp:
  - STEP and INTERVAL take effect at the next use.
  - TARGET is not re-latched until the next START.
- done_irq is set on ramp completion and cleared by a W1C to STATUS bit1. If set and clear occur in the same cycle, set wins.
- duty_out is registered: it equals current, or its gamma-corrected value. Latency is 1 cycle from the current update.

Optional Feature:
- Macro: PWM_FADE_GAMMA_EN.
- Defined: duty_out = (current*current)>>8, except current==255 gives 255. The product is 16-bit and duty_out is registered, so the 1-cycle latency is unchanged. Register 5 still reads the linear current.
- Undefined: duty_out = current, and no multiplier is instantiated.

Test Plan:
- Reset, then CURRENT=0, TARGET=100, STEP=30, INTERVAL=0, START → on successive ticks duty_out reads 30, 60, 90, 100, then busy=0 and done_irq=1. STATUS write 0x02 → done_irq=0.
- CURRENT=200, TARGET=10, STEP=0, INTERVAL=2 → duty decrements by 1 every 3 period_ticks. Reaches 10 after 570 ticks, never goes below 10.
- CURRENT=250, TARGET=255, STEP=20 → duty_out goes 250→255 in one step with no 8-bit wrap. Reverse case with CURRENT=5, TARGET=0 → 0.
- TRI=1, CURRENT=0, TARGET=64, STEP=32 → duty sequence 32, 64, 32, 0, 32, … with done never set. STOP while at 32 → holds 32, busy=0.
- START while busy with a new TARGET → ignored. CURRENT write while busy → ignored. rst_n low mid-ramp at duty 90 → duty_out=0 and busy=0 the next cycle.
- With PWM_FADE_GAMMA_EN: current 128 → duty_out 64, current 255 → 255, current 16 → 1. Without the macro, the same values pass through unchanged.

Source files
------------

// File: rtl/pwm_fade_ctrl.sv
// Duty-cycle fade sequencer for the 8-bit byte-peripheral PWM: one-shot ramps and triangle breathing.
// Optional build macro PWM_FADE_GAMMA_EN squares the duty (gamma correction) before it reaches the PWM.
//
// state  | meaning
// S_IDLE | no ramp running, CURRENT writable
// S_WAIT | counting period ticks until the next step
// S_STEP | one-cycle duty update toward the latched target
module pwm_fade_ctrl #(
  parameter int TICK_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] address,
  input  logic       data_write,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  input  logic       period_tick,
  output logic [7:0] duty_out,
  output logic       busy,
  output logic       done_irq
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_STEP} state_t;

  state_t            state_q, state_d;
  logic [7:0]        target_q, target_d;
  logic [7:0]        step_q, step_d;
  logic [TICK_W-1:0] interval_q, interval_d;
  logic [7:0]        current_q, current_d;
  logic [7:0]        start_pt_q, start_pt_d;
  logic [7:0]        tgt_q, tgt_d;
  logic              tri_q, tri_d;
  logic [TICK_W-1:0] tickcnt_q, tickcnt_d;
  logic              done_q, done_d;
  logic [7:0]        duty_q, duty_d;

  logic       wr_ctrl, start_req, stop_req, done_set, done_clr;
  logic [7:0] step_eff, up_val, dn_val, step_val;
  logic [8:0] sum9, diff9;

  assign busy     = (state_q != S_IDLE);
  assign done_irq = done_q;
  assign duty_out = duty_q;

  // STOP wins over START when both are set in the same write
  assign wr_ctrl   = data_write && (address == 4'd0);
  assign stop_req  = wr_ctrl && data_in[2];
  assign start_req = wr_ctrl && data_in[0] && !data_in[2];
  assign done_clr  = data_write && (address == 4'd4) && data_in[1];

  // 9-bit arithmetic so a step can never wrap past 255 or below 0
  assign step_eff = (step_q == 8'd0) ? 8'd1 : step_q;
  assign sum9     = {1'b0, current_q} + {1'b0, step_eff};
  assign diff9    = {1'b0, current_q} - {1'b0, step_eff};
  assign up_val   = (sum9 > {1'b0, tgt_q}) ? tgt_q : sum9[7:0];
  assign dn_val   = (diff9[8] || (diff9[7:0] < tgt_q)) ? tgt_q : diff9[7:0];
  assign step_val = (current_q < tgt_q) ? up_val :
                    (current_q > tgt_q) ? dn_val : tgt_q;

  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    step_d     = step_q;
    interval_d = interval_q;
    current_d  = current_q;
    start_pt_d = start_pt_q;
    tgt_d      = tgt_q;
    tri_d      = tri_q;
    tickcnt_d  = tickcnt_q;
    done_set   = 1'b0;

    if (data_write) begin
      case (address)
        4'd1:    target_d   = data_in;
        4'd2:    step_d     = data_in;
        4'd3:    interval_d = TICK_W'(data_in);
        default: ;
      endcase
    end

    case (state_q)
      S_IDLE: begin
        if (data_write && (address == 4'd5)) current_d = data_in;
        if (start_req) begin
          start_pt_d = current_q;
          tgt_d      = target_q;
          tri_d      = data_in[1];
          tickcnt_d  = '0;
          if ((current_q == target_q) && !data_in[1]) done_set = 1'b1;
          else                                        state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (stop_req) begin
          state_d = S_IDLE;
        end else if (period_tick) begin
          if (tickcnt_q == interval_q) begin
            state_d   = S_STEP;
            tickcnt_d = '0;
          end else begin
            tickcnt_d = tickcnt_q + TICK_W'(1);
          end
        end
      end
      S_STEP: begin
        if (stop_req) begin
          state_d = S_IDLE;
        end else begin
          current_d = step_val;
          state_d   = S_WAIT;
          if (step_val == tgt_q) begin
            if (tri_q) begin
              tgt_d      = start_pt_q;
              start_pt_d = tgt_q;
            end else begin
              state_d  = S_IDLE;
              done_set = 1'b1;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    done_d = done_q;
    if (done_clr) done_d = 1'b0;
    if (done_set) done_d = 1'b1;
  end

`ifdef PWM_FADE_GAMMA_EN
  logic [15:0] sq;
  assign sq = {8'b0, current_q} * {8'b0, current_q};
  // full scale is forced so the brightest level stays reachable
  assign duty_d = (current_q == 8'hFF) ? 8'hFF : 8'(sq >> 8);
`else
  assign duty_d = current_q;
`endif

  always_comb begin
    data_out = 8'h00;
    case (address)
      4'd0:    data_out = {6'b0, tri_q, busy};
      4'd1:    data_out = target_q;
      4'd2:    data_out = step_q;
      4'd3:    data_out = 8'(interval_q);
      4'd4:    data_out = {6'b0, done_q, busy};
      4'd5:    data_out = current_q;
      default: data_out = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      target_q   <= '0;
      step_q     <= '0;
      interval_q <= '0;
      current_q  <= '0;
      start_pt_q <= '0;
      tgt_q      <= '0;
      tri_q      <= 1'b0;
      tickcnt_q  <= '0;
      done_q     <= 1'b0;
      duty_q     <= '0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      step_q     <= step_d;
      interval_q <= interval_d;
      current_q  <= current_d;
      start_pt_q <= start_pt_d;
      tgt_q      <= tgt_d;
      tri_q      <= tri_d;
      tickcnt_q  <= tickcnt_d;
      done_q     <= done_d;
      duty_q     <= duty_d;
    end
  end

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Directed bench for pwm_fade_ctrl: table of one-shot ramps plus hand sequences for
// interval, triangle, stop, busy-ignore, reset abort and duty mapping.
module tb_pwm_fade_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] address = '0;
  logic       data_write = 1'b0;
  logic [7:0] data_in = '0;
  logic [7:0] data_out;
  logic       period_tick = 1'b0;
  logic [7:0] duty_out;
  logic       busy;
  logic       done_irq;

  int tests = 0;
  int fails = 0;

  pwm_fade_ctrl #(.TICK_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .address(address), .data_write(data_write),
    .data_in(data_in), .data_out(data_out), .period_tick(period_tick),
    .duty_out(duty_out), .busy(busy), .done_irq(done_irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] cur;
    logic [7:0] tgt;
    logic [7:0] stp;
    int         exp_first;
    int         exp_steps;
    int         exp_final;
  } ramp_vec_t;

  typedef struct {
    logic [7:0] cur;
    int         exp_gamma;
    int         exp_lin;
  } map_vec_t;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    address = a; data_in = d; data_write = 1'b1;
    @(negedge clk);
    data_write = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [7:0] d);
    @(negedge clk);
    address = a;
    #1 d = data_out;
  endtask

  task automatic tick();
    @(negedge clk);
    period_tick = 1'b1;
    @(negedge clk);
    period_tick = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  ramp_vec_t rv[6];
  map_vec_t  mv[4];

  initial begin
    logic [7:0] r;
    int steps, first, min_duty;

    rv[0] = '{cur: 8'd0,   tgt: 8'd100, stp: 8'd30,  exp_first: 30,  exp_steps: 4,  exp_final: 100};
    rv[1] = '{cur: 8'd250, tgt: 8'd255, stp: 8'd20,  exp_first: 255, exp_steps: 1,  exp_final: 255};
    rv[2] = '{cur: 8'd5,   tgt: 8'd0,   stp: 8'd20,  exp_first: 0,   exp_steps: 1,  exp_final: 0};
    rv[3] = '{cur: 8'd100, tgt: 8'd40,  stp: 8'd0,   exp_first: 99,  exp_steps: 60, exp_final: 40};
    rv[4] = '{cur: 8'd10,  tgt: 8'd200, stp: 8'd255, exp_first: 200, exp_steps: 1,  exp_final: 200};
    rv[5] = '{cur: 8'd77,  tgt: 8'd77,  stp: 8'd5,   exp_first: 77,  exp_steps: 0,  exp_final: 77};

    mv[0] = '{cur: 8'd128, exp_gamma: 64,  exp_lin: 128};
    mv[1] = '{cur: 8'd255, exp_gamma: 255, exp_lin: 255};
    mv[2] = '{cur: 8'd16,  exp_gamma: 1,   exp_lin: 16};
    mv[3] = '{cur: 8'd200, exp_gamma: 156, exp_lin: 200};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset duty", duty_out, 0);
    check("reset busy", busy, 0);
    check("reset done", done_irq, 0);
    for (int a = 0; a < 8; a++) begin
      rd(4'(a), r);
      check($sformatf("reset read addr %0d", a), r, 0);
    end

    // one-shot ramps, INTERVAL=0
    for (int i = 0; i < 6; i++) begin
      wr(4'd4, 8'h02);
      wr(4'd5, rv[i].cur);
      wr(4'd1, rv[i].tgt);
      wr(4'd2, rv[i].stp);
      wr(4'd3, 8'd0);
      wr(4'd0, 8'h01);
      steps = 0;
      first = -1;
      for (int k = 0; k < 400 && busy; k++) begin
        tick();
        steps++;
        if (k == 0) first = duty_out;
      end
      if (first < 0) first = duty_out;
      check($sformatf("ramp%0d finished", i), busy, 0);
      check($sformatf("ramp%0d first duty", i), first, rv[i].exp_first);
      check($sformatf("ramp%0d steps", i), steps, rv[i].exp_steps);
      check($sformatf("ramp%0d final duty", i), duty_out, rv[i].exp_final);
      check($sformatf("ramp%0d done", i), done_irq, 1);
      wr(4'd4, 8'h02);
      @(negedge clk);
      check($sformatf("ramp%0d done cleared", i), done_irq, 0);
    end

    // slow decrement: 1 per 3 ticks
    wr(4'd5, 8'd200);
    wr(4'd1, 8'd10);
    wr(4'd2, 8'd0);
    wr(4'd3, 8'd2);
    wr(4'd0, 8'h01);
    tick(); tick();
    check("interval no step yet", duty_out, 200);
    tick();
    check("interval first step", duty_out, 199);
    rd(4'd2, r);
    check("step reg reads raw 0", r, 0);
    min_duty = 255;
    for (int k = 4; k <= 569; k++) begin
      tick();
      if (duty_out < min_duty) min_duty = duty_out;
    end
    check("interval tick 569 duty", duty_out, 11);
    check("interval tick 569 busy", busy, 1);
    tick();
    check("interval tick 570 duty", duty_out, 10);
    check("interval tick 570 busy", busy, 0);
    check("interval done", done_irq, 1);
    tick();
    check("interval floor", (duty_out < min_duty) ? duty_out : min_duty, 10);
    wr(4'd4, 8'h02);

    // triangle breathing then STOP
    wr(4'd5, 8'd0);
    wr(4'd1, 8'd64);
    wr(4'd2, 8'd32);
    wr(4'd3, 8'd0);
    wr(4'd0, 8'h03);
    tick(); check("tri 1", duty_out, 32);
    tick(); check("tri 2", duty_out, 64);
    tick(); check("tri 3", duty_out, 32);
    tick(); check("tri 4", duty_out, 0);
    tick(); check("tri 5", duty_out, 32);
    check("tri busy", busy, 1);
    check("tri done never", done_irq, 0);
    rd(4'd0, r);
    check("tri ctrl read", r, 3);
    wr(4'd0, 8'h04);
    check("stop busy", busy, 0);
    tick();
    check("stop holds duty", duty_out, 32);
    check("stop no done", done_irq, 0);
    rd(4'd0, r);
    check("stop ctrl read", r, 2);

    // START / CURRENT writes while busy are ignored
    wr(4'd5, 8'd0);
    wr(4'd1, 8'd100);
    wr(4'd2, 8'd30);
    wr(4'd0, 8'h01);
    tick(); check("busy ramp 1", duty_out, 30);
    wr(4'd1, 8'd50);
    wr(4'd0, 8'h01);
    wr(4'd5, 8'd5);
    rd(4'd5, r);
    check("current write ignored", r, 30);
    rd(4'd1, r);
    check("target reg updated", r, 50);
    tick(); check("busy ramp 2", duty_out, 60);
    tick(); check("busy ramp 3", duty_out, 90);

    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort duty", duty_out, 0);
    check("abort busy", busy, 0);
    rst_n = 1'b1;
    rd(4'd1, r);
    check("abort target reg", r, 0);

    // completion and W1C in the same cycle: set wins
    wr(4'd1, 8'd10);
    wr(4'd2, 8'd10);
    wr(4'd0, 8'h01);
    @(negedge clk);
    period_tick = 1'b1;
    @(negedge clk);
    period_tick = 1'b0;
    address = 4'd4; data_in = 8'h02; data_write = 1'b1;
    @(negedge clk);
    data_write = 1'b0;
    check("set beats clear", done_irq, 1);
    check("set beats clear busy", busy, 0);
    wr(4'd4, 8'h02);
    @(negedge clk);
    check("w1c after collision", done_irq, 0);

    // START and STOP together: nothing starts
    wr(4'd1, 8'd200);
    wr(4'd0, 8'h05);
    check("start+stop busy", busy, 0);
    tick();
    check("start+stop duty", duty_out, 10);

    for (int i = 0; i < 4; i++) begin
      wr(4'd5, mv[i].cur);
      @(negedge clk);
`ifdef PWM_FADE_GAMMA_EN
      check($sformatf("map %0d", mv[i].cur), duty_out, mv[i].exp_gamma);
`else
      check($sformatf("map %0d", mv[i].cur), duty_out, mv[i].exp_lin);
`endif
      rd(4'd5, r);
      check($sformatf("map %0d linear read", mv[i].cur), r, mv[i].cur);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
